rtm_sequencer: RTL and testbench

Microprogrammed control sequencer that sits directly upstream of the 4×4-bit register-transfer datapath (four 4-bit registers, A/B bus muxes, 4-bit adder, write-back decoder). It stores a 16-word program, fetches and decodes one instruction at a time, and drives the datapath control lines that are otherwise set by hand. It also tracks the adder carry so conditional jumps can be made. The datapath's register clock is the same `clock`.

---
 rtl/rtm_pkg.sv | 50 +++++
 rtl/rtm_prog_mem.sv | 24 ++
 rtl/rtm_sequencer.sv | 140 ++++++++++++++
 tb/tb_rtm_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtm_pkg.sv
// Shared types and instruction field layout for the microprogrammed
// register-transfer sequencer.
package rtm_pkg;

    localparam int OP_LSB  = 10;
    localparam int D_LSB   = 8;
    localparam int SA_LSB  = 6;
    localparam int SB_LSB  = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        OP_LDI = 2'd0,
        OP_ADD = 2'd1,
        OP_ADC = 2'd2,
        OP_CTL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SUB_HALT = 2'd0,
        SUB_JMP  = 2'd1,
        SUB_JC   = 2'd2,
        SUB_NOP  = 2'd3
    } sub_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] d;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] imm;
    } instr_t;

    function automatic instr_t decode_fields(input logic [11:0] w);
        instr_t f;
        f.op  = op_e'(w[OP_LSB +: 2]);
        f.d   = w[D_LSB +: 2];
        f.sa  = w[SA_LSB +: 2];
        f.sb  = w[SB_LSB +: 2];
        f.imm = w[IMM_LSB +: 4];
        return f;
    endfunction

endpackage

// File: rtl/rtm_prog_mem.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module rtm_prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rtm_sequencer.sv
// Fetch/execute sequencer driving the 4x4-bit datapath control lines,
// with a carry flag for conditional jumps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | after reset; program may be written, start runs
//   S_FETCH  | ir <- mem[pc], pc <- pc + 1
//   S_EXEC   | control lines decoded from ir; jumps, cf update
//   S_HALTED | stopped by HALT; program may be written, start reruns
module rtm_sequencer
    import rtm_pkg::*;
#(
    parameter int PDEPTH = 16,
    parameter int IW     = 12
) (
    input  logic                      clock,
    input  logic                      ctl_clear,
    input  logic                      start,
    input  logic                      prog_we,
    input  logic [$clog2(PDEPTH)-1:0] prog_addr,
    input  logic [IW-1:0]             prog_data,
    input  logic                      carry_out,
    output logic [1:0]                ctl_d,
    output logic                      ctl_we,
    output logic [1:0]                ctl_sa,
    output logic [1:0]                ctl_sb,
    output logic                      ctl_add,
    output logic                      carry_in,
    output logic [3:0]                indata,
    output logic                      busy,
    output logic                      halted
);

    localparam int AW = $clog2(PDEPTH);

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic           cf_q, cf_d;
    logic [IW-1:0]  mem_rdata;
    logic           mem_we;
    instr_t         ins;

    // Writes are locked out while running so a fetch never races a write.
    assign mem_we = prog_we && ((state_q == S_IDLE) || (state_q == S_HALTED));

    rtm_prog_mem #(
        .DEPTH (PDEPTH),
        .WIDTH (IW)
    ) u_prog_mem (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    assign ins = decode_fields(ir_q);

    always_ff @(posedge clock) begin
        if (ctl_clear) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cf_q    <= cf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cf_d     = cf_q;
        ctl_d    = 2'd0;
        ctl_we   = 1'b0;
        ctl_sa   = 2'd0;
        ctl_sb   = 2'd0;
        ctl_add  = 1'b0;
        carry_in = 1'b0;
        indata   = 4'd0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cf_d    = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ins.op)
                    OP_LDI: begin
                        ctl_d  = ins.d;
                        ctl_we = 1'b1;
                        indata = ins.imm;
                    end
                    OP_ADD, OP_ADC: begin
                        ctl_add  = 1'b1;
                        ctl_sa   = ins.sa;
                        ctl_sb   = ins.sb;
                        ctl_d    = ins.d;
                        ctl_we   = 1'b1;
                        carry_in = (ins.op == OP_ADC) && cf_q;
                        cf_d     = carry_out;
                    end
                    OP_CTL: begin
                        case (sub_e'(ins.d))
                            SUB_HALT: state_d = S_HALTED;
                            SUB_JMP:  pc_d = ins.imm[AW-1:0];
                            SUB_JC: begin
                                if (cf_q) begin
                                    pc_d = ins.imm[AW-1:0];
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_rtm_sequencer.sv
// Bench for rtm_sequencer: behavioural datapath, instruction-level reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_rtm_sequencer;

    logic        clock = 1'b0;
    logic        ctl_clear = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [11:0] prog_data = 12'd0;
    logic        carry_out;
    logic [1:0]  ctl_d, ctl_sa, ctl_sb;
    logic        ctl_we, ctl_add, carry_in, busy, halted;
    logic [3:0]  indata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    rtm_sequencer #(.PDEPTH(16), .IW(12)) dut (
        .clock     (clock),
        .ctl_clear (ctl_clear),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .carry_out (carry_out),
        .ctl_d     (ctl_d),
        .ctl_we    (ctl_we),
        .ctl_sa    (ctl_sa),
        .ctl_sb    (ctl_sb),
        .ctl_add   (ctl_add),
        .carry_in  (carry_in),
        .indata    (indata),
        .busy      (busy),
        .halted    (halted)
    );

    // Behavioural datapath driven by the DUT's control lines.
    logic [3:0] dp_r [4];
    logic [4:0] dp_sum;
    assign dp_sum    = {1'b0, dp_r[ctl_sa]} + {1'b0, dp_r[ctl_sb]} + {4'd0, carry_in};
    assign carry_out = dp_sum[4];

    always @(posedge clock) begin
        cyc_n <= cyc_n + 1;
        if (ctl_we) dp_r[ctl_d] <= ctl_add ? dp_sum[3:0] : indata;
    end

    // Instruction-level reference model.
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALTED = 3;
    int          m_mode = M_IDLE;
    logic [3:0]  m_pc = 4'd0;
    logic [11:0] m_ir = 12'd0;
    logic        m_cf = 1'b0;
    logic [3:0]  m_regs [4];
    logic [11:0] m_mem [16];

    always @(posedge clock) begin : model
        logic [1:0] op, fd, fsa, fsb;
        logic [3:0] fimm;
        logic [4:0] s;
        op = m_ir[11:10]; fd = m_ir[9:8]; fsa = m_ir[7:6]; fsb = m_ir[5:4]; fimm = m_ir[3:0];
        if (m_mode == M_EXEC) begin
            if (op == 2'd0) begin
                m_regs[fd] = fimm;
            end else if (op != 2'd3) begin
                s = {1'b0, m_regs[fsa]} + {1'b0, m_regs[fsb]} + ((op == 2'd2) ? {4'd0, m_cf} : 5'd0);
                m_regs[fd] = s[3:0];
                m_cf = s[4];
            end
        end
        if ((m_mode == M_IDLE || m_mode == M_HALTED) && prog_we) m_mem[prog_addr] = prog_data;
        if (ctl_clear) begin
            m_mode = M_IDLE; m_pc = 4'd0; m_ir = 12'd0; m_cf = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALTED: if (start) begin m_mode = M_FETCH; m_pc = 4'd0; m_cf = 1'b0; end
                M_FETCH: begin m_ir = m_mem[m_pc]; m_pc = m_pc + 4'd1; m_mode = M_EXEC; end
                default: begin
                    m_mode = M_FETCH;
                    if (op == 2'd3) begin
                        if (fd == 2'd0) m_mode = M_HALTED;
                        else if (fd == 2'd1) m_pc = fimm;
                        else if (fd == 2'd2 && m_cf) m_pc = fimm;
                    end
                end
            endcase
        end
    end

    function automatic logic [14:0] model_out();
        logic [1:0] d = 0, sa = 0, sb = 0;
        logic       we = 0, add = 0, ci = 0;
        logic [3:0] imm = 0;
        if (m_mode == M_EXEC) begin
            case (m_ir[11:10])
                2'd0: begin d = m_ir[9:8]; we = 1; imm = m_ir[3:0]; end
                2'd1, 2'd2: begin
                    d = m_ir[9:8]; we = 1; add = 1; sa = m_ir[7:6]; sb = m_ir[5:4];
                    ci = (m_ir[11:10] == 2'd2) ? m_cf : 1'b0;
                end
                default: ;
            endcase
        end
        return {d, we, sa, sb, add, ci, imm, (m_mode == M_FETCH || m_mode == M_EXEC), (m_mode == M_HALTED)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("outputs", {17'd0, ctl_d, ctl_we, ctl_sa, ctl_sb, ctl_add, carry_in, indata, busy, halted},
                {17'd0, model_out()});
            chk("dp_regs", {16'd0, dp_r[3], dp_r[2], dp_r[1], dp_r[0]},
                {16'd0, m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        end
    end

    function automatic logic [11:0] enc(input int op, input int d, input int sa, input int sb, input int imm);
        enc = {op[1:0], d[1:0], sa[1:0], sb[1:0], imm[3:0]};
    endfunction

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic wr(input int a, input logic [11:0] w);
        prog_we = 1'b1; prog_addr = a[3:0]; prog_data = w;
        step();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clr();
        ctl_clear = 1'b1;
        step();
        ctl_clear = 1'b0;
    endtask

    logic [12:0] we_pat, h_pat;
    logic        ok_busy, we_seen, ci_seen, found;

    initial begin
        for (int i = 0; i < 4; i++) begin dp_r[i] = 4'd0; m_regs[i] = 4'd0; end
        for (int i = 0; i < 16; i++) m_mem[i] = 12'd0;

        // Reset
        step(); step();
        ctl_clear = 1'b0;
        chk_en = 1'b1;
        chk("reset_outputs", {ctl_d, ctl_we, ctl_sa, ctl_sb, ctl_add, carry_in, indata, busy, halted}, 0);

        // Program write after reset, exercised by running it
        wr(0, enc(0, 3, 0, 0, 9));
        wr(1, enc(3, 0, 0, 0, 0));
        go();
        repeat (4) step();
        chk("t1_halted", halted, 1);
        chk("t1_r3", dp_r[3], 9);

        // Load and add
        wr(0, enc(0, 0, 0, 0, 5));
        wr(1, enc(0, 1, 0, 0, 12));
        wr(2, enc(1, 2, 0, 1, 0));
        wr(3, enc(3, 0, 0, 0, 0));
        go();
        we_pat = '0; h_pat = '0;
        for (int j = 0; j <= 8; j++) begin
            we_pat[j] = ctl_we; h_pat[j] = halted;
            if (j < 8) step();
        end
        chk("t2_we_edges", we_pat, 13'b0_0000_0010_1010);
        chk("t2_halted_at8", h_pat, 13'b1_0000_0000);
        chk("t2_r2", dp_r[2], 1);
        chk("t2_model_cf", m_cf, 1);

        // Conditional jump over address 4
        wr(3, enc(3, 2, 0, 0, 6));
        wr(4, enc(3, 0, 0, 0, 0));
        wr(6, enc(2, 3, 0, 0, 0));
        wr(7, enc(3, 0, 0, 0, 0));
        go();
        h_pat = '0; ci_seen = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            h_pat[j] = halted;
            if (ctl_add && carry_in) ci_seen = 1'b1;
            if (j < 12) step();
        end
        chk("t3_halted_at12", h_pat, 13'b1_0000_0000_0000);
        chk("t3_carry_in", ci_seen, 1);
        chk("t3_r3", dp_r[3], 11);

        // PC wrap: all NOPs, then JMP 0 at the last word
        for (int a = 0; a < 16; a++) wr(a, enc(3, 3, 0, 0, 0));
        for (int pass = 0; pass < 2; pass++) begin
            go();
            ok_busy = 1'b1; we_seen = 1'b0;
            for (int j = 0; j < 40; j++) begin
                ok_busy &= busy; we_seen |= ctl_we;
                step();
            end
            chk("t4_busy", ok_busy, 1);
            chk("t4_no_we", we_seen, 0);
            clr();
            if (pass == 0) wr(15, enc(3, 1, 0, 0, 0));
        end

        // start/prog_we while busy are ignored
        wr(0, enc(0, 0, 0, 0, 3));
        wr(1, enc(3, 1, 0, 0, 0));
        go();
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            if (ctl_we) found = 1'b1; else step();
        end
        chk("t5_exec_found", found, 1);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = enc(3, 0, 0, 0, 0);
        step();
        start = 1'b0; prog_we = 1'b0;
        ok_busy = 1'b1;
        for (int j = 0; j < 12; j++) begin ok_busy &= busy & ~halted; step(); end
        chk("t5_still_running", ok_busy, 1);
        clr();

        // Reset during the EXEC of a carrying ADD
        wr(0, enc(0, 0, 0, 0, 15));
        wr(1, enc(0, 1, 0, 0, 1));
        wr(2, enc(1, 2, 0, 1, 0));
        wr(3, enc(3, 0, 0, 0, 0));
        go();
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (ctl_add) found = 1'b1; else step();
        end
        chk("t6_add_found", found, 1);
        chk("t6_carry_out", carry_out, 1);
        clr();
        chk("t6_we", ctl_we, 0);
        chk("t6_busy", busy, 0);
        chk("t6_halted", halted, 0);
        chk("t6_model_cf", m_cf, 0);

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            ctl_clear = ($urandom_range(63) == 0);
            prog_we   = !ctl_clear && ($urandom_range(4) == 0);
            prog_addr = 4'($urandom_range(15));
            prog_data = 12'($urandom);
            start     = ($urandom_range(7) == 0);
            step();
        end
        ctl_clear = 1'b0; prog_we = 1'b0; start = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
